// File: rtl/tlb_ptw_arbiter_pkg.sv
// Shared types for the ITLB/DTLB page-table-walker arbiter.
// Contents:
//   VPN_W/PPN_W/PTE_W/LEVEL_W  walk request and PTE field widths
//   ptw_arb_state_t            arbiter FSM states (IDLE, ISSUE, WAIT)
//   ptw_owner_t                which TLB owns the walk in flight
//   ptw_walk_req_t             latched walk request (vpn, prv, store, fetch)
//   pte_t                      packed PTE layout (ppn, rfs, d, a, g, u, x, w, r, v)
//   owner_of_grant             maps a one-hot 2-bit grant onto an owner
package tlb_ptw_arbiter_pkg;

    localparam int VPN_W   = 27;
    localparam int PPN_W   = 20;
    localparam int PTE_W   = 30;
    localparam int LEVEL_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } ptw_arb_state_t;

    typedef enum logic {
        OWNER_ITLB = 1'b0,
        OWNER_DTLB = 1'b1
    } ptw_owner_t;

    typedef struct packed {
        logic [VPN_W-1:0] vpn;
        logic [1:0]       prv;
        logic             store;
        logic             fetch;
    } ptw_walk_req_t;

    typedef struct packed {
        logic [PPN_W-1:0] ppn;
        logic [1:0]       rfs;
        logic             d;
        logic             a;
        logic             g;
        logic             u;
        logic             x;
        logic             w;
        logic             r;
        logic             v;
    } pte_t;

    // Grant bit 0 is the ITLB, bit 1 the DTLB.
    function automatic ptw_owner_t owner_of_grant(input logic [1:0] gnt);
        return gnt[0] ? OWNER_ITLB : OWNER_DTLB;
    endfunction

endpackage

// File: rtl/tlb_ptw_arbiter_if.sv
// Bundle of every TLB-side and PTW-side signal of the walker arbiter.
// Modports:
//   slave  - the arbiter: takes TLB miss requests and PTW responses,
//            drives the PTW request, per-TLB responses, invalidates, PMU pulses
//   master - the environment (both TLBs plus the PTW)
interface tlb_ptw_arbiter_if;
    import tlb_ptw_arbiter_pkg::*;

    // ITLB miss request
    logic               itlb_req_i_valid;
    logic [VPN_W-1:0]   itlb_req_i_vpn;
    logic [1:0]         itlb_req_i_prv;
    logic               itlb_req_ready_o;
    // DTLB miss request
    logic               dtlb_req_i_valid;
    logic [VPN_W-1:0]   dtlb_req_i_vpn;
    logic [1:0]         dtlb_req_i_prv;
    logic               dtlb_req_i_store;
    logic               dtlb_req_ready_o;
    // Walk request to the PTW
    logic               ptw_req_o_valid;
    logic [VPN_W-1:0]   ptw_req_o_addr;
    logic [1:0]         ptw_req_o_prv;
    logic               ptw_req_o_store;
    logic               ptw_req_o_fetch;
    logic               ptw_req_ready_i;
    // Walk response from the PTW
    logic               ptw_resp_i_valid;
    logic               ptw_resp_i_error;
    logic [PTE_W-1:0]   ptw_resp_i_pte;
    logic [LEVEL_W-1:0] ptw_resp_i_level;
    logic               ptw_invalidate_i;
    // Responses back to the TLBs
    logic               itlb_resp_o_valid;
    logic               dtlb_resp_o_valid;
    logic               itlb_resp_o_replay;
    logic               dtlb_resp_o_replay;
    logic               resp_o_error;
    logic [PTE_W-1:0]   resp_o_pte;
    logic [LEVEL_W-1:0] resp_o_level;
    logic               itlb_invalidate_o;
    logic               dtlb_invalidate_o;
    // Performance counters
    logic               pmu_ptw_walk_o;
    logic               pmu_ptw_stale_o;

    modport slave (
        input  itlb_req_i_valid, itlb_req_i_vpn, itlb_req_i_prv,
        input  dtlb_req_i_valid, dtlb_req_i_vpn, dtlb_req_i_prv, dtlb_req_i_store,
        input  ptw_req_ready_i,
        input  ptw_resp_i_valid, ptw_resp_i_error, ptw_resp_i_pte, ptw_resp_i_level,
        input  ptw_invalidate_i,
        output itlb_req_ready_o, dtlb_req_ready_o,
        output ptw_req_o_valid, ptw_req_o_addr, ptw_req_o_prv, ptw_req_o_store, ptw_req_o_fetch,
        output itlb_resp_o_valid, dtlb_resp_o_valid, itlb_resp_o_replay, dtlb_resp_o_replay,
        output resp_o_error, resp_o_pte, resp_o_level,
        output itlb_invalidate_o, dtlb_invalidate_o,
        output pmu_ptw_walk_o, pmu_ptw_stale_o
    );

    modport master (
        output itlb_req_i_valid, itlb_req_i_vpn, itlb_req_i_prv,
        output dtlb_req_i_valid, dtlb_req_i_vpn, dtlb_req_i_prv, dtlb_req_i_store,
        output ptw_req_ready_i,
        output ptw_resp_i_valid, ptw_resp_i_error, ptw_resp_i_pte, ptw_resp_i_level,
        output ptw_invalidate_i,
        input  itlb_req_ready_o, dtlb_req_ready_o,
        input  ptw_req_o_valid, ptw_req_o_addr, ptw_req_o_prv, ptw_req_o_store, ptw_req_o_fetch,
        input  itlb_resp_o_valid, dtlb_resp_o_valid, itlb_resp_o_replay, dtlb_resp_o_replay,
        input  resp_o_error, resp_o_pte, resp_o_level,
        input  itlb_invalidate_o, dtlb_invalidate_o,
        input  pmu_ptw_walk_o, pmu_ptw_stale_o
    );

endinterface

// File: rtl/tlb_ptw_arbiter_rr_arbiter2.sv
// Two-input round-robin grant.
// Ports:
//   clk, srst  clock and synchronous active-high reset
//   req[1:0]   request vector (bit 0 = ITLB, bit 1 = DTLB)
//   update     a grant was taken this cycle; remember its winner
//   gnt[1:0]   one-hot grant, zero when nothing requests
// On a tie the side that did not win last time gets the grant. Reset makes
// the DTLB the last winner so the ITLB wins the first tie.
module rr_arbiter2
    import tlb_ptw_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    ptw_owner_t rr_last_reg, rr_last_next;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (rr_last_reg == OWNER_DTLB) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_comb begin
        rr_last_next = rr_last_reg;
        if (update && (gnt != 2'b00)) begin
            rr_last_next = owner_of_grant(gnt);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rr_last_reg <= OWNER_DTLB;
        end else begin
            rr_last_reg <= rr_last_next;
        end
    end

endmodule

// File: rtl/tlb_ptw_arbiter.sv
// Shares one page-table walker between the ITLB and the DTLB.
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset (walker is reset alongside)
//   bus    tlb_ptw_arbiter_if.slave: TLB miss requests/readies, PTW request
//          and response, per-TLB response/replay, invalidate fan-out, PMU pulses
// One walk is in flight at a time: IDLE accepts a round-robin winner,
// ISSUE presents it to the PTW, WAIT routes the response to the owner only.
// An invalidate seen while a walk is in flight makes that walk stale: the
// owner then gets replay instead of a fill.
module tlb_ptw_arbiter
    import tlb_ptw_arbiter_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    tlb_ptw_arbiter_if.slave  bus
);

    ptw_arb_state_t state_reg, state_next;
    ptw_owner_t     owner_reg, owner_next;
    ptw_walk_req_t  req_reg,   req_next;
    logic           stale_reg, stale_next;

    logic [1:0] tlb_valid;
    logic [1:0] gnt;
    logic [1:0] ready_vec;
    logic [1:0] resp_valid_vec;
    logic [1:0] resp_replay_vec;
    logic       is_idle;
    logic       accept;
    logic       resp_fire;
    logic       stale_eff;
    pte_t       pte_in;

    assign tlb_valid = {bus.dtlb_req_i_valid, bus.itlb_req_i_valid};
    assign is_idle   = (state_reg == IDLE);
    // gnt is only non-zero when someone requests, so a grant in IDLE is a handshake.
    assign accept    = is_idle && (gnt != 2'b00);
    // Responses outside WAIT are protocol violations and are dropped here.
    assign resp_fire = (state_reg == WAIT) && bus.ptw_resp_i_valid;
    // An invalidate arriving with the response still spoils that response.
    assign stale_eff = stale_reg | bus.ptw_invalidate_i;
    assign pte_in    = pte_t'(bus.ptw_resp_i_pte);

    rr_arbiter2 u_rr (
        .clk    (clk_i),
        .srst   (rst_i),
        .req    (tlb_valid),
        .update (accept),
        .gnt    (gnt)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_tlb
            logic owns;
            assign owns                = ((owner_reg == OWNER_DTLB) == (gi == 1));
            assign ready_vec[gi]       = is_idle & gnt[gi];
            assign resp_valid_vec[gi]  = resp_fire & owns & ~stale_eff;
            assign resp_replay_vec[gi] = resp_fire & owns & stale_eff;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        req_next   = req_reg;
        stale_next = stale_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    owner_next     = owner_of_grant(gnt);
                    req_next.vpn   = gnt[0] ? bus.itlb_req_i_vpn : bus.dtlb_req_i_vpn;
                    req_next.prv   = gnt[0] ? bus.itlb_req_i_prv : bus.dtlb_req_i_prv;
                    req_next.store = gnt[0] ? 1'b0 : bus.dtlb_req_i_store;
                    req_next.fetch = gnt[0];
                    stale_next     = 1'b0;
                    state_next     = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.ptw_invalidate_i) begin
                    stale_next = 1'b1;
                end
                if (bus.ptw_req_ready_i) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.ptw_resp_i_valid) begin
                    stale_next = 1'b0;
                    state_next = IDLE;
                end else if (bus.ptw_invalidate_i) begin
                    stale_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            owner_reg <= OWNER_ITLB;
            req_reg   <= '0;
            stale_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            req_reg   <= req_next;
            stale_reg <= stale_next;
        end
    end

    assign bus.itlb_req_ready_o   = ready_vec[0];
    assign bus.dtlb_req_ready_o   = ready_vec[1];

    assign bus.ptw_req_o_valid    = (state_reg == ISSUE);
    assign bus.ptw_req_o_addr     = req_reg.vpn;
    assign bus.ptw_req_o_prv      = req_reg.prv;
    assign bus.ptw_req_o_store    = req_reg.store;
    assign bus.ptw_req_o_fetch    = req_reg.fetch;

    assign bus.itlb_resp_o_valid  = resp_valid_vec[0];
    assign bus.dtlb_resp_o_valid  = resp_valid_vec[1];
    assign bus.itlb_resp_o_replay = resp_replay_vec[0];
    assign bus.dtlb_resp_o_replay = resp_replay_vec[1];
    assign bus.resp_o_error       = resp_fire & bus.ptw_resp_i_error;
    assign bus.resp_o_pte         = resp_fire ? pte_in : '0;
    assign bus.resp_o_level       = resp_fire ? bus.ptw_resp_i_level : '0;

    assign bus.itlb_invalidate_o  = bus.ptw_invalidate_i;
    assign bus.dtlb_invalidate_o  = bus.ptw_invalidate_i;

    assign bus.pmu_ptw_walk_o     = accept;
    assign bus.pmu_ptw_stale_o    = resp_fire & stale_eff;

endmodule

// File: tb/tb_tlb_ptw_arbiter.sv
// Bench for tlb_ptw_arbiter: directed scenarios followed by random traffic,
// all checked cycle by cycle against a walk-level model of the arbiter.
module tb_tlb_ptw_arbiter;
    import tlb_ptw_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tlb_ptw_arbiter_if bus ();

    tlb_ptw_arbiter dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Values applied at the next step
    logic               d_rst, d_iv, d_dv, d_dst, d_prdy, d_rv, d_rerr, d_inv;
    logic [VPN_W-1:0]   d_ivpn, d_dvpn;
    logic [1:0]         d_iprv, d_dprv;
    logic [PTE_W-1:0]   d_rpte;
    logic [LEVEL_W-1:0] d_rlvl;

    // Walk-level model: is a walk waiting for the PTW to take it, is one
    // out at the PTW, who owns it, who won last, has it been invalidated.
    logic             m_pend, m_out, m_own_i, m_last_i, m_stale;
    logic [VPN_W-1:0] m_vpn;
    logic [1:0]       m_prv;
    logic             m_store;
    logic             acc_i, acc_d;

    int total = 0;
    int bad = 0;
    int walks = 0;
    int proto_cnt = 0;
    int i_skips = 0;
    int d_skips = 0;
    int gq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        d_rst = 0; d_iv = 0; d_dv = 0; d_dst = 0; d_prdy = 0; d_rv = 0;
        d_rerr = 0; d_inv = 0; d_ivpn = '0; d_dvpn = '0; d_iprv = 0; d_dprv = 0;
        d_rpte = '0; d_rlvl = '0;
    endtask

    task automatic apply();
        rst                  = d_rst;
        bus.itlb_req_i_valid = d_iv;
        bus.itlb_req_i_vpn   = d_ivpn;
        bus.itlb_req_i_prv   = d_iprv;
        bus.dtlb_req_i_valid = d_dv;
        bus.dtlb_req_i_vpn   = d_dvpn;
        bus.dtlb_req_i_prv   = d_dprv;
        bus.dtlb_req_i_store = d_dst;
        bus.ptw_req_ready_i  = d_prdy;
        bus.ptw_resp_i_valid = d_rv;
        bus.ptw_resp_i_error = d_rerr;
        bus.ptw_resp_i_pte   = d_rpte;
        bus.ptw_resp_i_level = d_rlvl;
        bus.ptw_invalidate_i = d_inv;
    endtask

    // One clock: drive on the falling edge, check 1ns later, then advance
    // the model to what the following rising edge should produce.
    task automatic step();
        logic idle, win_i, fire, st;
        @(negedge clk);
        apply();
        #1;
        acc_i = 0;
        acc_d = 0;
        if (d_rst) begin
            m_pend = 0; m_out = 0; m_own_i = 0; m_last_i = 0; m_stale = 0;
            m_vpn = '0; m_prv = 0; m_store = 0;
            i_skips = 0; d_skips = 0;
        end else begin
            idle  = !m_pend && !m_out;
            win_i = (d_iv && d_dv) ? !m_last_i : d_iv;
            acc_i = idle && d_iv && win_i;
            acc_d = idle && d_dv && !win_i;
            if (bus.itlb_req_ready_o && d_iv) gq.push_back(0);
            if (bus.dtlb_req_ready_o && d_dv) gq.push_back(1);

            chk("itlb_ready", bus.itlb_req_ready_o, acc_i);
            chk("dtlb_ready", bus.dtlb_req_ready_o, acc_d);
            chk("pmu_walk", bus.pmu_ptw_walk_o, acc_i | acc_d);
            chk("ptw_valid", bus.ptw_req_o_valid, m_pend);
            if (m_pend) begin
                chk("ptw_addr", bus.ptw_req_o_addr, m_vpn);
                chk("ptw_prv", bus.ptw_req_o_prv, m_prv);
                chk("ptw_store", bus.ptw_req_o_store, m_store);
                chk("ptw_fetch", bus.ptw_req_o_fetch, m_own_i);
            end

            if (d_rv && !m_out) begin
                proto_cnt++;
                $display("note: ptw response outside a walk, expected to be ignored");
            end
            fire = m_out && d_rv;
            st   = m_stale || d_inv;
            chk("itlb_resp", bus.itlb_resp_o_valid, fire && m_own_i && !st);
            chk("dtlb_resp", bus.dtlb_resp_o_valid, fire && !m_own_i && !st);
            chk("itlb_replay", bus.itlb_resp_o_replay, fire && m_own_i && st);
            chk("dtlb_replay", bus.dtlb_resp_o_replay, fire && !m_own_i && st);
            chk("pmu_stale", bus.pmu_ptw_stale_o, fire && st);
            chk("resp_pte", bus.resp_o_pte, fire ? d_rpte : '0);
            chk("resp_err", bus.resp_o_error, fire && d_rerr);
            chk("resp_lvl", bus.resp_o_level, fire ? d_rlvl : '0);
            chk("itlb_inv", bus.itlb_invalidate_o, d_inv);
            chk("dtlb_inv", bus.dtlb_invalidate_o, d_inv);

            if (fire) begin
                walks++;
                $display("walk %0d owner=%s vpn=%h pte=%h %s", walks,
                         m_own_i ? "itlb" : "dtlb", m_vpn, d_rpte, st ? "replay" : "fill");
            end

            // No TLB may see more than one foreign walk start while it waits.
            if (d_iv && !acc_i && acc_d) i_skips++;
            if (d_dv && !acc_d && acc_i) d_skips++;
            if (acc_i) begin chk("starve_i", i_skips <= 1, 1); i_skips = 0; end
            if (acc_d) begin chk("starve_d", d_skips <= 1, 1); d_skips = 0; end

            if (m_out) begin
                if (d_rv) begin m_out = 0; m_stale = 0; end
                else if (d_inv) m_stale = 1;
            end else if (m_pend) begin
                if (d_inv) m_stale = 1;
                if (d_prdy) begin m_pend = 0; m_out = 1; end
            end else if (acc_i || acc_d) begin
                m_pend   = 1;
                m_own_i  = acc_i;
                m_last_i = acc_i;
                m_stale  = 0;
                m_vpn    = acc_i ? d_ivpn : d_dvpn;
                m_prv    = acc_i ? d_iprv : d_dprv;
                m_store  = acc_i ? 1'b0 : d_dst;
            end
        end
    endtask

    task automatic do_reset();
        idle_in();
        d_rst = 1;
        step();
        step();
        d_rst = 0;
        step();
    endtask

    // A full walk for one TLB starting from IDLE with nothing else requesting.
    task automatic do_walk(input bit use_i, input logic [VPN_W-1:0] vpn, input bit inv_wait,
                           input bit inv_resp);
        if (use_i) begin d_iv = 1; d_ivpn = vpn; d_iprv = 2'd1; end
        else begin d_dv = 1; d_dvpn = vpn; d_dprv = 2'd3; d_dst = 1; end
        step();
        d_iv = 0; d_dv = 0; d_prdy = 1;
        step();
        d_prdy = 0;
        if (inv_wait) begin d_inv = 1; step(); d_inv = 0; end
        d_rv = 1; d_rpte = PTE_W'($urandom); d_rlvl = LEVEL_W'($urandom); d_inv = inv_resp;
        step();
        d_rv = 0; d_inv = 0;
    endtask

    initial begin
        idle_in();
        d_rst = 1;
        apply();
        do_reset();
        chk("rst_ptw_valid", bus.ptw_req_o_valid, 0);
        chk("rst_addr", bus.ptw_req_o_addr, 0);

        // 1: ITLB alone
        d_iv = 1; d_ivpn = 27'h1234567; d_iprv = 2'd1;
        step();
        chk("t1_ready", bus.itlb_req_ready_o, 1);
        d_iv = 0; d_prdy = 1;
        step();
        chk("t1_valid", bus.ptw_req_o_valid, 1);
        chk("t1_addr", bus.ptw_req_o_addr, 27'h1234567);
        chk("t1_fetch", bus.ptw_req_o_fetch, 1);
        d_prdy = 0; d_rv = 1; d_rpte = 30'h0ABCDE3F;
        step();
        chk("t1_resp", bus.itlb_resp_o_valid, 1);
        chk("t1_pte", bus.resp_o_pte, 30'h0ABCDE3F);
        chk("t1_dresp", bus.dtlb_resp_o_valid, 0);
        idle_in();

        // 2: both requesting from reset alternate I, D, I, D
        do_reset();
        gq.delete();
        d_iv = 1; d_ivpn = 27'h0000ABC; d_dv = 1; d_dvpn = 27'h7FFFFFF; d_dst = 1; d_prdy = 1;
        for (int c = 0; c < 12; c++) begin
            d_rv = m_out;
            step();
        end
        idle_in();
        step();
        chk("t2_count", gq.size(), 4);
        if (gq.size() >= 4) begin
            for (int k = 0; k < 4; k++) chk("t2_order", gq[k], k % 2);
        end

        // 3: PTW back-pressure for 5 cycles, DTLB kept waiting meanwhile
        d_iv = 1; d_ivpn = 27'h0055AA1;
        step();
        d_iv = 0; d_dv = 1; d_dvpn = 27'h0123456; d_dprv = 2'd2;
        for (int c = 0; c < 5; c++) step();
        chk("t3_hold", bus.ptw_req_o_valid, 1);
        d_prdy = 1;
        step();
        d_prdy = 0; d_rv = 1;
        step();
        d_rv = 0;
        step();
        chk("t3_dgrant", bus.dtlb_req_ready_o, 1);
        d_dv = 0; d_prdy = 1;
        step();
        d_prdy = 0; d_rv = 1;
        step();
        idle_in();

        // 4: invalidate during WAIT -> replay, then a clean re-request
        do_walk(0, 27'h0FEDCBA, 1, 0);
        chk("t4_replay", bus.dtlb_resp_o_replay, 1);
        chk("t4_stale", bus.pmu_ptw_stale_o, 1);
        do_walk(0, 27'h0FEDCBA, 0, 0);
        chk("t4_refill", bus.dtlb_resp_o_valid, 1);

        // 5: reset while in WAIT, then a stray response
        d_iv = 1; d_ivpn = 27'h1111111;
        step();
        d_iv = 0; d_prdy = 1;
        step();
        idle_in();
        d_rst = 1;
        step();
        d_rst = 0;
        d_rv = 1; d_rpte = 30'h3FFFFFFF;
        step();
        chk("t5_noresp", bus.itlb_resp_o_valid, 0);
        chk("t5_addr", bus.ptw_req_o_addr, 0);
        idle_in();

        // 6: invalidate with the response, then invalidate while idle
        do_walk(1, 27'h0222222, 0, 1);
        chk("t6_replay", bus.itlb_resp_o_replay, 1);
        d_inv = 1;
        step();
        d_inv = 0;
        do_walk(1, 27'h0222222, 0, 0);
        chk("t6_fill", bus.itlb_resp_o_valid, 1);
        chk("t6_noreplay", bus.itlb_resp_o_replay, 0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if (!d_iv && $urandom_range(0, 2) == 0) begin
                d_iv = 1; d_ivpn = VPN_W'($urandom); d_iprv = 2'($urandom);
            end
            if (!d_dv && $urandom_range(0, 2) == 0) begin
                d_dv = 1; d_dvpn = VPN_W'($urandom); d_dprv = 2'($urandom); d_dst = 1'($urandom);
            end
            d_prdy = 1'($urandom);
            d_rv   = m_out && ($urandom_range(0, 2) == 0);
            d_rerr = 1'($urandom);
            d_rpte = PTE_W'($urandom);
            d_rlvl = LEVEL_W'($urandom);
            d_inv  = ($urandom_range(0, 9) == 0);
            d_rst  = ($urandom_range(0, 499) == 0);
            step();
            if (acc_i) d_iv = 0;
            if (acc_d) d_dv = 0;
        end
        idle_in();
        step();

        chk("proto_cnt", proto_cnt, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tlb_ptw_arbiter.md
Name: tlb_ptw_arbiter

Overview:
Shares the single page-table walker between the instruction TLB and the data TLB. Each TLB raises a miss request. The arbiter grants one at a time (round-robin), latches it, and drives it to the PTW. It then routes the walk response back to the owning TLB only. It also broadcasts PTW invalidates to both TLBs. A walk in flight when an invalidate arrives is marked stale, and its owner is told to replay instead of filling.

Parameters:
VPN_W, 27, virtual page number width of walk request
PPN_W, 20, physical page number width in PTE
PTE_W, 30, packed PTE width (ppn, rfs[1:0], d, a, g, u, x, w, r, v)
LEVEL_W, 2, walk level field width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
itlb_req_i_valid  in  1  ITLB miss request
itlb_req_i_vpn  in  VPN_W  ITLB miss VPN
itlb_req_i_prv  in  2  ITLB privilege
itlb_req_ready_o  out  1  ITLB request accepted this cycle when valid
dtlb_req_i_valid  in  1  DTLB miss request
dtlb_req_i_vpn  in  VPN_W  DTLB miss VPN
dtlb_req_i_prv  in  2  DTLB privilege
dtlb_req_i_store  in  1  DTLB miss is a store
dtlb_req_ready_o  out  1  DTLB request accepted this cycle when valid
ptw_req_o_valid  out  1  walk request to PTW
ptw_req_o_addr  out  VPN_W  latched VPN
ptw_req_o_prv  out  2  latched privilege
ptw_req_o_store  out  1  latched store (0 for ITLB)
ptw_req_o_fetch  out  1  1 when owner is ITLB
ptw_req_ready_i  in  1  PTW accepts request
ptw_resp_i_valid  in  1  walk response
ptw_resp_i_error  in  1  walk fault
ptw_resp_i_pte  in  PTE_W  packed PTE
ptw_resp_i_level  in  LEVEL_W  leaf level
ptw_invalidate_i  in  1  TLB shootdown
itlb_resp_o_valid, dtlb_resp_o_valid  out  1 each  response for that TLB, fill allowed
itlb_resp_o_replay, dtlb_resp_o_replay  out  1 each  stale walk ended; owner must re-request
resp_o_error  out  1  shared error, qualified by the per-TLB valid
resp_o_pte  out  PTE_W  shared PTE, qualified by the per-TLB valid
resp_o_level  out  LEVEL_W  shared level, qualified by the per-TLB valid
itlb_invalidate_o, dtlb_invalidate_o  out  1 each  copy of ptw_invalidate_i
pmu_ptw_walk_o  out  1  one-cycle pulse per issued walk
pmu_ptw_stale_o  out  1  one-cycle pulse per stale-dropped walk

Behaviour:
- Reset (rst_i=1 at the edge): state IDLE; rr_last=DTLB, so ITLB wins the first tie; stale=0.
  - All registered outputs are 0 and all latched request fields are 0.
  - Reset mid-walk abandons the walk. The PTW is reset by the same reset.
- States:
  - IDLE: accepts a request.
  - ISSUE: ptw_req_o_valid=1, waiting for ptw_req_ready_i.
  - WAIT: waiting for ptw_resp_i_valid.
- Grant in IDLE (combinational):
  - Only one requester valid: that one is granted.
  - Both valid: the one not equal to rr_last is granted.
  - Only the granted requester's ready is 1. Both readies are 0 outside IDLE.
- Accept (valid&ready):
  - Latch vpn, prv, store, fetch and owner; set rr_last=owner; go to ISSUE.
  - ptw_req_o_valid rises the next cycle. Latency from request to PTW request is 1 cycle.
  - pmu_ptw_walk_o pulses in the accept cycle.
- ISSUE: ptw_req_o_valid held and fields stable until ptw_req_ready_i=1; then go to WAIT and deassert the next cycle.
- WAIT, response routing:
  - Response is routed combinationally in the cycle ptw_resp_i_valid=1; pte, error and level pass through unmodified.
  - If stale=0: owner's resp_o_valid=1.
  - If stale=1: owner's replay=1, resp_o_valid=0, and pmu_ptw_stale_o pulses.
  - The non-owner sees valid=0 and replay=0.
  - Next state is IDLE; clear stale. A new request is accepted no earlier than the cycle after the response.
- Invalidate:
  - The *_invalidate_o outputs follow ptw_invalidate_i combinationally in every state.
  - In ISSUE or WAIT, an invalidate sets stale=1.
  - An invalidate in the same cycle as the response also counts as stale for that response.
  - In IDLE it does not set stale.
- ptw_resp_i_valid in IDLE or ISSUE is a protocol violation: ignored, no output. A bench assertion flags it.
- Starvation bound: a continuously requesting TLB waits at most one complete walk of the other TLB.

Decomposition:
- mmu_pkg gains the following, and the module uses them internally:
  - ptw_arb_state_t (IDLE, ISSUE, WAIT);
  - ptw_owner_t (OWNER_ITLB, OWNER_DTLB);
  - a packed ptw_walk_req_t (vpn, prv, store, fetch).
- The PTE layout reuses the existing pte fields.
- Natural sub-module: rr_arbiter2, a 2-input round-robin grant with rr_last register, around 30 lines. Everything else stays flat.

Test Plan:
1. ITLB only: itlb valid, vpn=0x1234567, prv=1 -> ready same cycle; next cycle ptw_req_o_valid=1, addr=0x1234567, fetch=1, store=0. Response pte=0x0ABCDE3F -> itlb_resp_o_valid=1 with that pte; dtlb_resp_o_valid=0.
2. Both request in cycle 0 after reset -> ITLB granted first. DTLB (vpn=0x7FFFFFF, store=1) is issued after the ITLB response with store=1, fetch=0. Repeating both requests alternates grants ITLB, DTLB, ITLB, DTLB.
3. Hold ptw_req_ready_i=0 for 5 cycles -> ptw_req_o_valid stays 1 with stable fields; both TLB readies 0; WAIT is entered only after ready=1.
4. ptw_invalidate_i pulse during WAIT, then response -> both *_invalidate_o pulse; owner replay=1, resp_o_valid=0, pmu_ptw_stale_o=1. Next owner request is accepted and completes normally.
5. rst_i asserted in WAIT -> next cycle state IDLE, all outputs 0. A late ptw_resp_i_valid produces no TLB response.
6. Invalidate coincident with the response, and invalidate in IDLE -> the first gives replay; the second leaves the next walk non-stale.
